// File: rtl/id_ex_reg_if.sv
// id_ex_reg_if: decode-side, write-back and EX-side signal bundle for the ID/EX pipeline register.
//   master : hazard/decode/write-back side, drives stall, flush, in_*, RW/busW/RegWrite
//   slave  : the ID/EX register, drives the ex_* fields and bubble_cnt
interface id_ex_reg_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int CW    = 16
);
    logic             stall;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_instr;
    logic [AW-1:0]    in_ra;
    logic [AW-1:0]    in_rb;
    logic [WIDTH-1:0] in_busA;
    logic [WIDTH-1:0] in_busB;
    logic [AW-1:0]    in_rd;
    logic             in_regwrite;
    logic [WIDTH-1:0] in_imm32;
    logic [AW-1:0]    RW;
    logic [WIDTH-1:0] busW;
    logic             RegWrite;
    logic             ex_valid;
    logic [WIDTH-1:0] ex_pc;
    logic [WIDTH-1:0] ex_instr;
    logic [WIDTH-1:0] ex_busA;
    logic [WIDTH-1:0] ex_busB;
    logic [WIDTH-1:0] ex_imm32;
    logic [AW-1:0]    ex_ra;
    logic [AW-1:0]    ex_rb;
    logic [AW-1:0]    ex_rd;
    logic             ex_regwrite;
    logic [CW-1:0]    bubble_cnt;

    modport master (
        output stall, flush, in_valid, in_pc, in_instr, in_ra, in_rb, in_busA, in_busB,
               in_rd, in_regwrite, in_imm32, RW, busW, RegWrite,
        input  ex_valid, ex_pc, ex_instr, ex_busA, ex_busB, ex_imm32, ex_ra, ex_rb, ex_rd,
               ex_regwrite, bubble_cnt
    );

    modport slave (
        input  stall, flush, in_valid, in_pc, in_instr, in_ra, in_rb, in_busA, in_busB,
               in_rd, in_regwrite, in_imm32, RW, busW, RegWrite,
        output ex_valid, ex_pc, ex_instr, ex_busA, ex_busB, ex_imm32, ex_ra, ex_rb, ex_rd,
               ex_regwrite, bubble_cnt
    );
endinterface

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with stall, flush, write-back bypass and a saturating bubble counter.
//   clk   : rising-edge clock
//   reset : asynchronous active-high clear of every output
//   bus   : id_ex_reg_if slave (decode inputs, write-back snoop, registered EX outputs)
module id_ex_reg #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int CW    = 16
) (
    input logic        clk,
    input logic        reset,
    id_ex_reg_if.slave bus
);
    logic             wbLive;
    logic [WIDTH-1:0] loadA;
    logic [WIDTH-1:0] loadB;
    logic [WIDTH-1:0] holdA;
    logic [WIDTH-1:0] holdB;
    logic [CW-1:0]    cntNext;

    // The GRF writes on the same edge decode reads it, so a live write-back
    // to a nonzero register must override the stale read data.
    assign wbLive  = bus.RegWrite && (bus.RW != '0);
    assign loadA   = (wbLive && bus.RW == bus.in_ra) ? bus.busW : bus.in_busA;
    assign loadB   = (wbLive && bus.RW == bus.in_rb) ? bus.busW : bus.in_busB;
    // While stalled, a held instruction keeps watching write-back so its operands stay current.
    assign holdA   = (bus.ex_valid && wbLive && bus.RW == bus.ex_ra) ? bus.busW : bus.ex_busA;
    assign holdB   = (bus.ex_valid && wbLive && bus.RW == bus.ex_rb) ? bus.busW : bus.ex_busB;
    assign cntNext = bus.bubble_cnt + CW'(bus.bubble_cnt != '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset || bus.flush) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_pc       <= '0;
            bus.ex_instr    <= '0;
            bus.ex_busA     <= '0;
            bus.ex_busB     <= '0;
            bus.ex_imm32    <= '0;
            bus.ex_ra       <= '0;
            bus.ex_rb       <= '0;
            bus.ex_rd       <= '0;
            bus.ex_regwrite <= 1'b0;
            bus.bubble_cnt  <= reset ? '0 : cntNext;
        end else if (bus.stall) begin
            bus.ex_busA <= holdA;
            bus.ex_busB <= holdB;
        end else begin
            bus.ex_valid    <= bus.in_valid;
            bus.ex_pc       <= bus.in_pc;
            bus.ex_instr    <= bus.in_instr;
            bus.ex_busA     <= loadA;
            bus.ex_busB     <= loadB;
            bus.ex_imm32    <= bus.in_imm32;
            bus.ex_ra       <= bus.in_ra;
            bus.ex_rb       <= bus.in_rb;
            bus.ex_rd       <= bus.in_rd;
            bus.ex_regwrite <= bus.in_regwrite && bus.in_valid;
            bus.bubble_cnt  <= bus.in_valid ? bus.bubble_cnt : cntNext;
        end
    end
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: randomized and directed checks of id_ex_reg against a behavioural model.
module tb_id_ex_reg;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    bit doCheck = 1'b1;

    typedef struct {
        logic        valid;
        logic [31:0] pc, instr, busA, busB, imm;
        logic [4:0]  ra, rb, rd;
        logic        rw;
        int          cnt;
    } model_t;
    model_t m;

    id_ex_reg_if #(.WIDTH(32), .AW(5), .CW(16)) bus ();
    id_ex_reg #(.WIDTH(32), .AW(5), .CW(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clearModel();
        m.valid = 0; m.pc = 0; m.instr = 0; m.busA = 0; m.busB = 0; m.imm = 0;
        m.ra = 0; m.rb = 0; m.rd = 0; m.rw = 0;
    endtask

    task automatic checkAll(input string tag);
        checkEq({tag, ".valid"}, 32'(bus.ex_valid), 32'(m.valid));
        checkEq({tag, ".pc"}, bus.ex_pc, m.pc);
        checkEq({tag, ".instr"}, bus.ex_instr, m.instr);
        checkEq({tag, ".busA"}, bus.ex_busA, m.busA);
        checkEq({tag, ".busB"}, bus.ex_busB, m.busB);
        checkEq({tag, ".imm"}, bus.ex_imm32, m.imm);
        checkEq({tag, ".ra"}, 32'(bus.ex_ra), 32'(m.ra));
        checkEq({tag, ".rb"}, 32'(bus.ex_rb), 32'(m.rb));
        checkEq({tag, ".rd"}, 32'(bus.ex_rd), 32'(m.rd));
        checkEq({tag, ".regwrite"}, 32'(bus.ex_regwrite), 32'(m.rw));
        checkEq({tag, ".cnt"}, 32'(bus.bubble_cnt), 32'(m.cnt));
    endtask

    // One clock edge: the model applies the priority rules to the inputs present at the edge.
    task automatic step(input string tag);
        logic wb;
        @(posedge clk);
        wb = bus.RegWrite && bus.RW != 0;
        if (bus.flush) begin
            clearModel();
            m.cnt = (m.cnt < 65535) ? m.cnt + 1 : 65535;
        end else if (bus.stall) begin
            if (m.valid && wb && bus.RW == m.ra) m.busA = bus.busW;
            if (m.valid && wb && bus.RW == m.rb) m.busB = bus.busW;
        end else begin
            m.valid = bus.in_valid;
            m.pc = bus.in_pc;
            m.instr = bus.in_instr;
            m.imm = bus.in_imm32;
            m.ra = bus.in_ra;
            m.rb = bus.in_rb;
            m.rd = bus.in_rd;
            m.rw = bus.in_regwrite && bus.in_valid;
            m.busA = (wb && bus.RW == bus.in_ra) ? bus.busW : bus.in_busA;
            m.busB = (wb && bus.RW == bus.in_rb) ? bus.busW : bus.in_busB;
            if (!bus.in_valid) m.cnt = (m.cnt < 65535) ? m.cnt + 1 : 65535;
        end
        #1;
        if (doCheck) checkAll(tag);
    endtask

    task automatic idleInputs();
        bus.stall = 0; bus.flush = 0; bus.in_valid = 0; bus.in_pc = 0; bus.in_instr = 0;
        bus.in_ra = 0; bus.in_rb = 0; bus.in_busA = 0; bus.in_busB = 0; bus.in_rd = 0;
        bus.in_regwrite = 0; bus.in_imm32 = 0; bus.RW = 0; bus.busW = 0; bus.RegWrite = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1;
        #1;
        clearModel();
        m.cnt = 0;
        checkAll("reset");
        @(negedge clk);
        reset = 0;
    endtask

    task automatic randomInputs();
        bus.stall = ($urandom_range(0, 3) == 0);
        bus.flush = ($urandom_range(0, 7) == 0);
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_pc = $urandom; bus.in_instr = $urandom; bus.in_imm32 = $urandom;
        bus.in_busA = $urandom; bus.in_busB = $urandom; bus.busW = $urandom;
        bus.in_ra = 5'($urandom_range(0, 3)); bus.in_rb = 5'($urandom_range(0, 3));
        bus.in_rd = 5'($urandom); bus.in_regwrite = 1'($urandom);
        bus.RW = 5'($urandom_range(0, 3)); bus.RegWrite = 1'($urandom);
    endtask

    initial begin
        idleInputs();
        clearModel();
        m.cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("resetHeld");
        @(negedge clk);
        reset = 0;

        // 1: plain load
        bus.in_valid = 1; bus.in_ra = 5; bus.in_busA = 32'h11;
        step("load");
        checkEq("t1.busA", bus.ex_busA, 32'h11);
        checkEq("t1.valid", 32'(bus.ex_valid), 1);

        // 2: same-edge bypass, and none for $0
        bus.in_ra = 12; bus.in_busA = 0; bus.RegWrite = 1; bus.RW = 12; bus.busW = 1234;
        step("bypass");
        checkEq("t2.bypass", bus.ex_busA, 1234);
        bus.in_ra = 0; bus.RW = 0;
        step("bypassR0");
        checkEq("t2.r0", bus.ex_busA, 0);

        // 3: stalled operand refresh, hit and miss
        bus.RegWrite = 0; bus.in_rb = 13; bus.in_busB = 7;
        step("preStall");
        bus.stall = 1; bus.RegWrite = 1; bus.RW = 13; bus.busW = 32'hABCD;
        bus.in_pc = 32'h5555; bus.in_busB = 32'h99;
        step("stallHit");
        checkEq("t3.hit", bus.ex_busB, 32'hABCD);
        checkEq("t3.pcHeld", bus.ex_pc, 0);
        bus.stall = 0; bus.RegWrite = 0; bus.in_busB = 7; bus.in_pc = 0;
        step("reload");
        bus.stall = 1; bus.RegWrite = 1; bus.RW = 14;
        step("stallMiss");
        checkEq("t3.miss", bus.ex_busB, 7);

        // 4: flush beats stall, invalid load suppresses regwrite
        doReset();
        idleInputs();
        bus.in_valid = 1; bus.in_regwrite = 1; bus.in_busA = 32'h42;
        step("rwLoad");
        bus.flush = 1; bus.stall = 1;
        step("flushStall");
        checkEq("t4.valid", 32'(bus.ex_valid), 0);
        checkEq("t4.rw", 32'(bus.ex_regwrite), 0);
        checkEq("t4.busA", bus.ex_busA, 0);
        checkEq("t4.cnt", 32'(bus.bubble_cnt), 1);
        bus.flush = 0; bus.stall = 0; bus.in_valid = 0;
        step("bubbleLoad");
        checkEq("t4.rw2", 32'(bus.ex_regwrite), 0);
        checkEq("t4.cnt2", 32'(bus.bubble_cnt), 2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            randomInputs();
            step("rand");
        end

        // 5: saturation
        doReset();
        idleInputs();
        doCheck = 0;
        for (int i = 0; i < 65536; i++) step("sat");
        doCheck = 1;
        checkEq("t5.sat", 32'(bus.bubble_cnt), 32'hFFFF);
        step("satHold");
        checkEq("t5.hold", 32'(bus.bubble_cnt), 32'hFFFF);

        // 6: asynchronous reset while stalled
        bus.in_valid = 1; bus.in_pc = 32'h1234; bus.in_busA = 32'h77;
        step("preReset");
        bus.stall = 1;
        step("stalled");
        #2;
        reset = 1;
        #1;
        clearModel();
        m.cnt = 0;
        checkAll("asyncReset");
        @(negedge clk);
        reset = 0;
        idleInputs();
        bus.in_valid = 1; bus.in_pc = 32'h3000;
        step("postReset");
        checkEq("t6.pc", bus.ex_pc, 32'h3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
